// File: rtl/vending_pkg.sv
// Shared coin codes and acceptor state type for the vending front end.
package vending_pkg;

   localparam logic [1:0] COIN_NONE   = 2'b00;
   localparam logic [1:0] COIN_NICKEL = 2'b01;
   localparam logic [1:0] COIN_DIME   = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      QUAL,
      EMIT,
      RELEASE,
      REJECT
   } acc_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous sensor line.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/coin_acceptor.sv
// Coin slot front end: synchronizes and debounces the nickel/dime sensors and
// emits one single-cycle coin code per inserted coin, returning invalid coins.
module coin_acceptor
   import vending_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 8,
   parameter int unsigned CNT_W           = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       nickel_sense,
   input  logic       dime_sense,
   input  logic       accept_en,
   output logic [1:0] coin,
   output logic       coin_return,
   output logic       busy
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   acc_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             lat_dime;
   logic             n_s, d_s;
   logic             lat_hi, other_hi;

   sync_2ff u_sync_nickel (.clk(clk), .rst(rst), .d(nickel_sense), .q(n_s));
   sync_2ff u_sync_dime   (.clk(clk), .rst(rst), .d(dime_sense),   .q(d_s));

   always_comb begin
      lat_hi   = lat_dime ? d_s : n_s;
      other_hi = lat_dime ? n_s : d_s;
   end

   // Outputs are assigned alongside the state they belong to, so they track the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         lat_dime    <= 1'b0;
         coin        <= COIN_NONE;
         coin_return <= 1'b0;
         busy        <= 1'b0;
      end else begin
         coin <= COIN_NONE;
         case (state)
            IDLE: begin
               if (n_s || d_s) begin
                  busy <= 1'b1;
                  if (accept_en && (n_s != d_s)) begin
                     state    <= QUAL;
                     lat_dime <= d_s;
                     cnt      <= CNT_ONE;
                  end else begin
                     state       <= REJECT;
                     coin_return <= 1'b1;
                     cnt         <= '0;
                  end
               end
            end
            QUAL: begin
               if (other_hi || !accept_en) begin
                  state       <= REJECT;
                  coin_return <= 1'b1;
                  cnt         <= '0;
               end else if (!lat_hi) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= EMIT;
                  coin  <= lat_dime ? COIN_DIME : COIN_NICKEL;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            EMIT: begin
               state <= RELEASE;
               cnt   <= '0;
            end
            RELEASE, REJECT: begin
               // Exit happens the cycle after the count fills, giving the full pulse spacing.
               if (cnt == CNT_FULL) begin
                  state       <= IDLE;
                  coin_return <= 1'b0;
                  busy        <= 1'b0;
                  cnt         <= '0;
               end else if (!n_s && !d_s) begin
                  cnt <= cnt + CNT_ONE;
               end else begin
                  cnt <= '0;
               end
            end
            default: begin
               state       <= IDLE;
               coin_return <= 1'b0;
               busy        <= 1'b0;
               cnt         <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_coin_acceptor.sv
// Randomized scoreboard bench for coin_acceptor with a run-length reference model.
module tb_coin_acceptor;
   import vending_pkg::*;

   localparam int DC   = 4;
   localparam int MAXN = 8192;

   logic       clk = 1'b1;
   logic       rst = 1'b1;
   logic       nickel_sense = 1'b0;
   logic       dime_sense = 1'b0;
   logic       accept_en = 1'b0;
   logic [1:0] coin;
   logic       coin_return;
   logic       busy;

   coin_acceptor #(.DEBOUNCE_CYCLES(DC), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .nickel_sense(nickel_sense), .dime_sense(dime_sense),
      .accept_en(accept_en), .coin(coin), .coin_return(coin_return), .busy(busy)
   );

   always #5 clk = ~clk;

   bit st_rst[MAXN], st_n[MAXN], st_d[MAXN], st_en[MAXN], busy_exp[MAXN];
   int last_rst[MAXN];
   int n_stim = 0;

   typedef struct {
      bit         is_ret;
      logic [1:0] code;
      int         edge_at;
      int         end_at;
   } ev_t;
   ev_t exp_q[$];

   int errors = 0;
   int checks = 0;

   function automatic void chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endfunction

   function automatic void put(bit r, bit n, bit d, bit en, int len);
      for (int i = 0; i < len; i++)
         if (n_stim < MAXN) begin
            st_rst[n_stim] = r; st_n[n_stim] = n; st_d[n_stim] = d; st_en[n_stim] = en;
            n_stim++;
         end
   endfunction

   // Synced value the acceptor sees at edge j: raw value from two edges earlier, zero after reset.
   function automatic bit sn(int j);
      if (j < 2 || j - 2 <= last_rst[j]) return 1'b0;
      return st_n[j-2];
   endfunction
   function automatic bit sd(int j);
      if (j < 2 || j - 2 <= last_rst[j]) return 1'b0;
      return st_d[j-2];
   endfunction

   // Edge at which DC consecutive all-clear samples have been seen, starting at s.
   function automatic int rel_end(int s, int b);
      int run = 0;
      for (int t = s; t <= b; t++) begin
         if (!sn(t) && !sd(t)) run++; else run = 0;
         if (run == DC) return t;
      end
      return -1;
   endfunction

   function automatic void mark_busy(int from, int upto);
      for (int t = from; t <= upto; t++) busy_exp[t] = 1'b1;
   endfunction

   function automatic int reject(int from, int start, int b);
      int r, fin;
      r   = rel_end(start + 1, b);
      fin = (r < 0 || r + 1 > b) ? b + 1 : r + 1;
      exp_q.push_back('{1'b1, COIN_NONE, start, fin});
      mark_busy(from, fin - 1);
      return fin + 1;
   endfunction

   function automatic void model_segment(int a, int b);
      int j, m, last, r;
      bit n, d, hi, oth;
      j = a;
      while (j <= b) begin
         n = sn(j); d = sd(j);
         if (!n && !d) begin
            j++;
         end else if ((n != d) && st_en[j]) begin
            m = -1;
            last = j + DC - 1;
            for (int t = j + 1; t <= last && t <= b; t++) begin
               hi  = n ? sn(t) : sd(t);
               oth = n ? sd(t) : sn(t);
               if (m < 0 && !(hi && !oth && st_en[t])) m = t;
            end
            if (m < 0) begin
               if (last > b) begin mark_busy(j, b); return; end
               exp_q.push_back('{1'b0, n ? COIN_NICKEL : COIN_DIME, last, 0});
               r = rel_end(last + 2, b);
               if (r < 0 || r + 1 > b) begin mark_busy(j, b); return; end
               mark_busy(j, r);
               j = r + 2;
            end else begin
               oth = n ? sd(m) : sn(m);
               if (oth || !st_en[m]) j = reject(j, m, b);
               else begin mark_busy(j, m - 1); j = m + 1; end
            end
         end else begin
            j = reject(j, j, b);
         end
      end
   endfunction

   function automatic void run_model();
      int lr = -1, a;
      for (int k = 0; k < n_stim; k++) begin
         if (st_rst[k]) lr = k;
         last_rst[k] = lr;
         busy_exp[k] = 1'b0;
      end
      a = 0;
      while (a < n_stim) begin
         if (st_rst[a]) a++;
         else begin
            int b = a;
            while (b + 1 < n_stim && !st_rst[b+1]) b++;
            model_segment(a, b);
            a = b + 1;
         end
      end
   endfunction

   function automatic void build_stimulus();
      int kind, len;
      bit ty;
      put(1, 0, 0, 1, 3);
      put(0, 0, 0, 1, 4);
      put(0, 1, 0, 1, 20); put(0, 0, 0, 1, 14);                       // clean nickel
      put(0, 0, 1, 1, 2);  put(0, 0, 0, 1, 14);                       // dime glitch
      for (int i = 0; i < 3; i++) begin put(0, 1, 0, 1, 1); put(0, 0, 0, 1, 1); end
      put(0, 1, 0, 1, 12);
      for (int i = 0; i < 3; i++) begin put(0, 0, 0, 1, 1); put(0, 1, 0, 1, 1); end
      put(0, 0, 0, 1, 14);                                            // bouncy nickel
      put(0, 1, 1, 1, 6);  put(0, 0, 0, 1, 2); put(0, 1, 0, 1, 1);
      put(0, 0, 0, 1, 14);                                            // both sensors
      put(0, 0, 1, 0, 6);  put(0, 0, 0, 1, 14);                       // dime, intake disabled
      put(0, 1, 0, 1, 4);  put(0, 1, 0, 0, 2); put(0, 1, 0, 1, 2);
      put(0, 0, 0, 1, 14);                                            // enable dropped mid-qualify
      put(0, 1, 0, 1, 4);  put(1, 1, 0, 1, 2); put(0, 1, 0, 1, 12);
      put(0, 0, 0, 1, 14);                                            // reset mid-qualify
      put(0, 0, 1, 1, 6);  put(0, 0, 0, 1, 5); put(0, 1, 0, 1, 6);
      put(0, 0, 0, 1, 14);                                            // back-to-back coins
      for (int it = 0; it < 100; it++) begin
         kind = $urandom_range(0, 9);
         ty   = 1'($urandom_range(0, 1));
         case (kind)
            0, 1, 2, 3, 4: begin
               for (int bn = $urandom_range(0, 3); bn > 0; bn--) begin
                  put(0, !ty, ty, 1, $urandom_range(1, 2));
                  put(0, 0, 0, 1, $urandom_range(1, 2));
               end
               put(0, !ty, ty, 1, $urandom_range(1, 10));
               for (int bn = $urandom_range(0, 3); bn > 0; bn--) begin
                  put(0, 0, 0, 1, $urandom_range(1, 2));
                  put(0, !ty, ty, 1, $urandom_range(1, 2));
               end
            end
            5: put(0, 1, 1, 1, $urandom_range(1, 6));
            6, 7: begin
               len = $urandom_range(1, 8);
               for (int i = 0; i < len; i++)
                  put(0, !ty, ty, ($urandom_range(0, 3) != 0), 1);
            end
            8: put(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, $urandom_range(1, 2));
            default: put(0, !ty, ty, 1, $urandom_range(1, 3));
         endcase
         put(0, 0, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 12));
      end
      put(0, 0, 0, 1, 3 * DC + 8);
   endfunction

   initial begin
      build_stimulus();
      run_model();
      fork
         begin : driver
            for (int k = 0; k < n_stim; k++) begin
               @(negedge clk);
               rst          = st_rst[k];
               nickel_sense = st_n[k];
               dime_sense   = st_d[k];
               accept_en    = st_en[k];
            end
         end
         begin : monitor
            ev_t ev;
            bit  ret_prev = 1'b0;
            int  ret_end = -1;
            for (int k = 0; k < n_stim; k++) begin
               @(posedge clk);
               #1;
               if (st_rst[k]) chk("reset_outputs", int'({coin, coin_return, busy}), 0);
               chk("busy", int'(busy), int'(busy_exp[k]));
               if (coin != COIN_NONE) begin
                  if (exp_q.size() == 0) chk("unexpected_coin", int'(coin), 0);
                  else begin
                     ev = exp_q.pop_front();
                     chk("coin_kind", 0, int'(ev.is_ret));
                     chk("coin_code", int'(coin), int'(ev.code));
                     chk("coin_edge", k, ev.edge_at);
                  end
               end
               if (coin_return && !ret_prev) begin
                  if (exp_q.size() == 0) chk("unexpected_return", 1, 0);
                  else begin
                     ev = exp_q.pop_front();
                     chk("return_kind", 1, int'(ev.is_ret));
                     chk("return_start", k, ev.edge_at);
                     ret_end = ev.end_at;
                  end
               end
               if (!coin_return && ret_prev) chk("return_end", k, ret_end);
               ret_prev = coin_return;
            end
         end
      join
      chk("leftover_events", exp_q.size(), 0);
      chk("final_idle", int'({coin, coin_return, busy}), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
